// File: rtl/oled_text_writer_pkg.sv
// oled_text_writer_pkg: shared constants, types and helpers for the OLED text writer.
package oled_pkg;
  localparam int OLED_ROWS = 4;
  localparam int OLED_COLS = 16;
  localparam int OLED_CELLS = OLED_ROWS * OLED_COLS;
  localparam logic [7:0] BLANK_CHAR = 8'h20;
  localparam int LO_TIMEOUT = 4;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LO, WAIT_HI, CLEAR, CWAIT_LO, CWAIT_HI} wr_state_t;
  typedef logic [5:0] cell_idx_t;
  function automatic logic [6:0] popcnt(input logic [OLED_CELLS-1:0] v);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < OLED_CELLS; i++) n += {6'd0, v[i]};
    return n;
  endfunction
endpackage

// File: rtl/oled_text_writer_if.sv
// oled_text_writer_if: host write port plus oledDriver command handshake.
interface oled_text_writer_if;
  logic       wr_en;
  logic [1:0] wr_row;
  logic [3:0] wr_col;
  logic [7:0] wr_char;
  logic       clr_req;
  logic       drv_ready;
  logic       drv_showchar;
  logic       drv_clear;
  logic [7:0] drv_charval;
  logic [1:0] drv_char_row;
  logic [3:0] drv_char_col;
  logic       busy;
  logic [6:0] dirty_cnt;
  modport master (
    output wr_en, wr_row, wr_col, wr_char, clr_req, drv_ready,
    input  drv_showchar, drv_clear, drv_charval, drv_char_row, drv_char_col, busy, dirty_cnt
  );
  modport slave (
    input  wr_en, wr_row, wr_col, wr_char, clr_req, drv_ready,
    output drv_showchar, drv_clear, drv_charval, drv_char_row, drv_char_col, busy, dirty_cnt
  );
endinterface

// File: rtl/oled_text_writer_rr_pick.sv
// oled_rr_pick: first set dirty bit at or after ptr_i, wrapping around the 64 cells.
module oled_rr_pick
  import oled_pkg::*;
(
  input  logic [OLED_CELLS-1:0] dirty_i,
  input  cell_idx_t             ptr_i,
  output logic                  found_o,
  output cell_idx_t             idx_o
);
  logic [OLED_CELLS-1:0] rot;
  cell_idx_t off;
  always_comb begin
    rot = OLED_CELLS'({dirty_i, dirty_i} >> ptr_i);
    off = '0;
    for (int i = OLED_CELLS - 1; i >= 0; i--) off = rot[i] ? cell_idx_t'(i) : off;
  end
  assign found_o = |dirty_i;
  assign idx_o = ptr_i + off;
endmodule

// File: rtl/oled_text_writer.sv
// oled_text_writer: 4x16 character buffer that replays only dirty cells to oledDriver.
module oled_text_writer #(
  parameter logic [7:0] BLANK_CHAR = oled_pkg::BLANK_CHAR,
  parameter int         LO_TIMEOUT = oled_pkg::LO_TIMEOUT
) (
  input logic clk,
  input logic rst_n,
  oled_text_writer_if.slave bus
);
  import oled_pkg::*;
  wr_state_t st_q;
  logic [7:0] buf_q [OLED_CELLS];
  logic [7:0] buf_d [OLED_CELLS];
  logic [OLED_CELLS-1:0] dirty_q, dirty_d;
  logic pend_q, pend_d;
  logic [6:0] cnt_q;
  cell_idx_t rr_q, pick, widx;
  logic [7:0] tmo_q;
  logic show_q, clr_q;
  logic [7:0] charval_q;
  logic [1:0] row_q;
  logic [3:0] col_q;
  logic found, take, lo_exit;
  oled_rr_pick u_pick (.dirty_i(dirty_q), .ptr_i(rr_q), .found_o(found), .idx_o(pick));
  assign widx = {bus.wr_row, bus.wr_col};
  assign take = st_q == IDLE && bus.drv_ready && !pend_q && found;
  assign lo_exit = !bus.drv_ready || tmo_q == 8'(LO_TIMEOUT - 1);
  // Later assignments win: blanking, then dirty-clear of the picked cell, then the host write.
  always_comb begin
    buf_d = buf_q;
    dirty_d = dirty_q;
    pend_d = (pend_q && st_q != CLEAR) || bus.clr_req;
    if (st_q == CLEAR) begin
      buf_d = '{default: BLANK_CHAR};
      dirty_d = '0;
    end
    if (take) dirty_d[pick] = 1'b0;
    if (bus.wr_en) begin
      buf_d[widx] = bus.wr_char;
      dirty_d[widx] = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      buf_q <= '{default: BLANK_CHAR};
      dirty_q <= '0;
      pend_q <= 1'b1;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      dirty_q <= dirty_d;
      pend_q <= pend_d;
      cnt_q <= popcnt(dirty_d);
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st_q <= IDLE;
      rr_q <= '0;
      tmo_q <= '0;
      show_q <= 1'b0;
      clr_q <= 1'b0;
      charval_q <= '0;
      row_q <= '0;
      col_q <= '0;
    end else begin
      show_q <= 1'b0;
      clr_q <= 1'b0;
      case (st_q)
        IDLE:
          if (bus.drv_ready && pend_q) begin
            st_q <= CLEAR;
            clr_q <= 1'b1;
          end else if (take) begin
            st_q <= ISSUE;
            show_q <= 1'b1;
            charval_q <= buf_q[pick];
            row_q <= pick[5:4];
            col_q <= pick[3:0];
          end
        ISSUE: begin
          st_q <= WAIT_LO;
          tmo_q <= '0;
          rr_q <= {row_q, col_q} + 6'd1;
        end
        CLEAR: begin
          st_q <= CWAIT_LO;
          tmo_q <= '0;
        end
        WAIT_LO, CWAIT_LO: begin
          tmo_q <= tmo_q + 8'd1;
          if (lo_exit) st_q <= st_q == WAIT_LO ? WAIT_HI : CWAIT_HI;
        end
        WAIT_HI, CWAIT_HI: if (bus.drv_ready) st_q <= IDLE;
        default: st_q <= IDLE;
      endcase
    end
  assign bus.drv_showchar = show_q;
  assign bus.drv_clear = clr_q;
  assign bus.drv_charval = charval_q;
  assign bus.drv_char_row = row_q;
  assign bus.drv_char_col = col_q;
  assign bus.dirty_cnt = cnt_q;
  assign bus.busy = st_q != IDLE || |dirty_q || pend_q;
endmodule

// File: tb/tb_oled_text_writer.sv
// tb_oled_text_writer: scoreboard bench; a monitor matches every driver pulse against queued expectations.
module tb_oled_text_writer;
  typedef struct packed {
    logic       clr;
    logic [7:0] ch;
    logic [1:0] row;
    logic [3:0] col;
  } exp_t;
  logic clk, rst_n;
  int total, bad, hold, cyc, last_cyc, gap;
  exp_t q[$];
  oled_text_writer_if bus();
  oled_text_writer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [5:0] idx, input logic [7:0] c);
    bus.wr_en = 1;
    bus.wr_row = idx[5:4];
    bus.wr_col = idx[3:0];
    bus.wr_char = c;
    tick();
    bus.wr_en = 0;
  endtask
  task automatic push_show(input logic [5:0] idx, input logic [7:0] c);
    q.push_back('{clr: 1'b0, ch: c, row: idx[5:4], col: idx[3:0]});
  endtask
  task automatic push_clr();
    q.push_back('{clr: 1'b1, ch: 8'h00, row: 2'd0, col: 4'd0});
  endtask
  task automatic wait_idle(input int lim);
    int n = 0;
    while (bus.busy && n < lim) begin
      tick();
      n++;
    end
    chk("idle_reached", 32'(n < lim), 1);
    chk("idle_dirty_cnt", 32'(bus.dirty_cnt), 0);
  endtask
  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end
  // Driver model: drops ready for `hold` cycles after each pulse; hold=0 never drops it.
  initial begin
    bus.drv_ready = 1;
    forever begin
      tick();
      if (rst_n && (bus.drv_showchar || bus.drv_clear) && hold > 0) begin
        bus.drv_ready = 0;
        repeat (hold) @(posedge clk);
        #1;
        bus.drv_ready = 1;
      end
    end
  end
  initial begin
    exp_t e, a;
    last_cyc = 0;
    gap = 0;
    forever begin
      @(negedge clk);
      if (rst_n && (bus.drv_showchar || bus.drv_clear)) begin
        gap = cyc - last_cyc;
        last_cyc = cyc;
        a = bus.drv_clear ? '{clr: 1'b1, ch: 8'h00, row: 2'd0, col: 4'd0}
                          : '{clr: 1'b0, ch: bus.drv_charval, row: bus.drv_char_row, col: bus.drv_char_col};
        if (q.size() == 0) chk("unexpected_pulse", 32'(a), 32'h7fff_ffff);
        else begin
          e = q.pop_front();
          chk("pulse", 32'(a), 32'(e));
        end
      end
    end
  end
  initial begin
    total = 0;
    bad = 0;
    hold = 2;
    bus.wr_en = 0;
    bus.wr_row = 0;
    bus.wr_col = 0;
    bus.wr_char = 0;
    bus.clr_req = 0;
    rst_n = 1;
    #2 rst_n = 0;
    repeat (3) tick();
    chk("rst_showchar", 32'(bus.drv_showchar), 0);
    chk("rst_clear", 32'(bus.drv_clear), 0);
    chk("rst_charval", 32'(bus.drv_charval), 0);
    chk("rst_row", 32'(bus.drv_char_row), 0);
    chk("rst_col", 32'(bus.drv_char_col), 0);
    chk("rst_dirty_cnt", 32'(bus.dirty_cnt), 0);
    chk("rst_busy", 32'(bus.busy), 1);
    push_clr();
    rst_n = 1;
    wait_idle(50);
    wr(6'd37, 8'h41);
    push_show(6'd37, 8'h41);
    chk("wr_dirty_cnt1", 32'(bus.dirty_cnt), 1);
    tick();
    chk("wr_latency", 32'(bus.drv_showchar), 1);
    chk("wr_dirty_cnt0", 32'(bus.dirty_cnt), 0);
    wait_idle(50);
    push_clr();
    bus.clr_req = 1;
    tick();
    bus.clr_req = 0;
    tick();
    chk("clr_latency", 32'(bus.drv_clear), 1);
    wait_idle(50);
    hold = 10;
    for (int i = 0; i < 64; i++) push_show(6'(i), 8'(8'h30 + i));
    for (int i = 0; i < 64; i++) wr(6'(i), 8'(8'h30 + i));
    wait_idle(3000);
    chk("burst_drained", 32'(q.size()), 0);
    hold = 2;
    push_show(6'd3, 8'h31);
    push_show(6'd3, 8'h32);
    wr(6'd3, 8'h31);
    wr(6'd3, 8'h32);
    chk("race_dirty_cnt", 32'(bus.dirty_cnt), 1);
    wait_idle(50);
    hold = 3;
    push_show(6'd10, 8'h55);
    push_clr();
    push_show(6'd7, 8'h77);
    wr(6'd10, 8'h55);
    tick();
    chk("inflight_show", 32'(bus.drv_showchar), 1);
    tick();
    tick();
    bus.clr_req = 1;
    tick();
    bus.clr_req = 0;
    begin
      int n = 0;
      while (!bus.drv_clear && n < 20) begin
        tick();
        n++;
      end
      chk("pending_clear_seen", 32'(n < 20), 1);
    end
    wr(6'd7, 8'h77);
    chk("clr_edge_dirty_cnt", 32'(bus.dirty_cnt), 1);
    wait_idle(80);
    hold = 0;
    push_show(6'd20, 8'h61);
    push_show(6'd21, 8'h62);
    wr(6'd20, 8'h61);
    wr(6'd21, 8'h62);
    wait_idle(100);
    chk("timeout_gap", 32'(gap), 7);
    wr(6'd1, 8'h11);
    tick();
    chk("mid_show", 32'(bus.drv_showchar), 1);
    rst_n = 0;
    #1;
    chk("mid_rst_show", 32'(bus.drv_showchar), 0);
    chk("mid_rst_charval", 32'(bus.drv_charval), 0);
    chk("mid_rst_busy", 32'(bus.busy), 1);
    push_clr();
    tick();
    rst_n = 1;
    wait_idle(100);
    repeat (5) tick();
    chk("queue_empty", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
